// File: rtl/axis_block_average.sv
// AXI-Stream decimating averager: sums frames of 2^LOG2_LEN samples and emits one
// averaged beat per frame, with backpressure and a frame-length error flag.
module axis_block_average #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_LEN   = 1,
    parameter bit SIGNED     = 1'b0,
    parameter bit ROUND      = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_err,
    input  logic                  m_ready
);

    // One guard bit beyond DATA_WIDTH+LOG2_LEN keeps the rounding increment from overflowing.
    localparam int ACC_W = DATA_WIDTH + LOG2_LEN + 1;
    localparam logic [LOG2_LEN-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] RND_INC = ROUND ? (ACC_W'(1) << (LOG2_LEN - 1)) : {ACC_W{1'b0}};

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      data_ext;
    logic [ACC_W-1:0]      acc_next;
    logic [ACC_W-1:0]      sum;
    logic [LOG2_LEN-1:0]   cnt;
    logic [DATA_WIDTH-1:0] avg_arith;
    logic [DATA_WIDTH-1:0] avg_logic;
    logic [DATA_WIDTH-1:0] avg;
    logic                  accept;
    logic                  count_full;
    logic                  closing;

    assign s_ready    = resetn & (~m_valid | m_ready);
    assign accept     = s_valid & s_ready;
    assign count_full = (cnt == CNT_MAX);
    assign closing    = accept & (s_last | count_full);

    assign data_ext = SIGNED ? {{(LOG2_LEN + 1){s_data[DATA_WIDTH-1]}}, s_data}
                             : {{(LOG2_LEN + 1){1'b0}}, s_data};

    assign acc_next = acc + data_ext;
    assign sum      = acc_next + RND_INC;

    // Separate shifts so the arithmetic one is never coerced to unsigned by a shared ternary.
    assign avg_arith = DATA_WIDTH'($signed(sum) >>> LOG2_LEN);
    assign avg_logic = DATA_WIDTH'(sum >> LOG2_LEN);
    assign avg       = SIGNED ? avg_arith : avg_logic;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_err   <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
        end else if (closing) begin
            m_valid <= 1'b1;
            m_data  <= avg;
            m_last  <= s_last;
            m_err   <= s_last ^ count_full;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept) begin
                acc <= acc_next;
                cnt <= cnt + LOG2_LEN'(1);
            end
        end
    end

endmodule
